// File: rtl/text_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : text_ctrl
//  Purpose  : Command sequencer for the double-buffered text RAM. Turns
//             CPU command/data pairs into byte writes on the back buffer,
//             tracks the text cursor and defers buffer swaps to the rising
//             edge of vertical blanking so scanout never tears.
//  Ports    : clk        - pixel clock, rising edge
//             rst        - asynchronous reset, active low
//             cmd_valid  - command present
//             cmd_code   - 00 STORE_BYTE, 01 MOVE_CURSOR, 10 DISPLAY, 11 CLEAR
//             cmd_data   - command operand
//             cmd_ready  - command accepted when cmd_valid && cmd_ready
//             vblank     - vertical blanking, synchronous to clk
//             wr_en      - RAM write strobe (one byte per cycle)
//             wr_buf     - buffer index of the write (the back buffer)
//             wr_addr    - byte address y*2*COLS + x
//             wr_data    - byte to write
//             active_buf - buffer currently scanned out
//             busy       - high while clearing or waiting for a swap
//  Config   : TEXT_CTRL_CLEAR_EN - when defined, CLEAR sweeps the back
//             buffer; otherwise command 11 is a single-cycle no-op.
//  Revision : 1.0 - initial release
// ============================================================================
module text_ctrl #(
    parameter int COLS = 80,
    parameter int ROWS = 60,
    parameter int AW   = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    input  logic [1:0]    cmd_code,
    input  logic [7:0]    cmd_data,
    output logic          cmd_ready,
    input  logic          vblank,
    output logic          wr_en,
    output logic          wr_buf,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          active_buf,
    output logic          busy
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_SWAP_WAIT = 2'd2;
`ifdef TEXT_CTRL_CLEAR_EN
    localparam logic [1:0] c_CLEAR     = 2'd1;
    localparam logic [AW-1:0] c_LAST_ADDR = AW'(2 * COLS * ROWS - 1);
`endif

    localparam logic [7:0]    c_LAST_X    = 8'(2 * COLS - 1);
    localparam logic [5:0]    c_LAST_Y    = 6'(ROWS - 1);
    localparam logic [6:0]    c_LAST_CELL = 7'(COLS - 1);
    localparam logic [AW-1:0] c_ROW_BYTES = AW'(2 * COLS);

    logic [1:0]    state_q, state_d;
    logic [7:0]    x_q, x_d;
    logic [5:0]    y_q, y_d;
    logic          act_q, act_d;
    logic          vb_prev_q;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          wr_buf_q;
    logic          busy_q;
`ifdef TEXT_CTRL_CLEAR_EN
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;   // next sweep address
    logic [7:0]    colour_q, colour_d;     // colour byte latched at accept
`endif

    logic          w_accept;
    logic [AW-1:0] w_cur_addr;

    assign cmd_ready  = (state_q == c_IDLE);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_cur_addr = AW'(y_q) * c_ROW_BYTES + AW'(x_q);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        act_d     = act_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef TEXT_CTRL_CLEAR_EN
        clr_cnt_d = clr_cnt_q;
        colour_d  = colour_q;
`endif
        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    case (cmd_code)
                        2'b00: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = w_cur_addr;
                            wr_data_d = cmd_data;
                            if (x_q == c_LAST_X) begin
                                x_d = 8'd0;
                                y_d = (y_q == c_LAST_Y) ? 6'd0 : y_q + 6'd1;
                            end else begin
                                x_d = x_q + 8'd1;
                            end
                        end
                        2'b01: begin
                            if (cmd_data[7]) begin
                                y_d = (cmd_data[5:0] > c_LAST_Y) ? c_LAST_Y : cmd_data[5:0];
                            end else begin
                                // Operand is a cell column; the byte column is twice that.
                                x_d = {((cmd_data[6:0] > c_LAST_CELL) ? c_LAST_CELL : cmd_data[6:0]), 1'b0};
                            end
                        end
                        2'b10: begin
                            state_d = c_SWAP_WAIT;
                        end
                        default: begin
`ifdef TEXT_CTRL_CLEAR_EN
                            // Address 0 is written on the accept edge so the sweep
                            // starts in the very next cycle.
                            state_d   = c_CLEAR;
                            colour_d  = cmd_data;
                            wr_en_d   = 1'b1;
                            wr_addr_d = '0;
                            wr_data_d = 8'h00;
                            clr_cnt_d = AW'(1);
`endif
                        end
                    endcase
                end
            end
            c_SWAP_WAIT: begin
                if (vblank && !vb_prev_q) begin
                    act_d   = ~act_q;
                    state_d = c_IDLE;
                end
            end
`ifdef TEXT_CTRL_CLEAR_EN
            c_CLEAR: begin
                // The last address is already on the bus: finish the sweep
                // once that write cycle has elapsed.
                if (wr_addr_q == c_LAST_ADDR) begin
                    state_d = c_IDLE;
                    x_d     = 8'd0;
                    y_d     = 6'd0;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = clr_cnt_q;
                    wr_data_d = clr_cnt_q[0] ? colour_q : 8'h00;
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
`endif
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= c_IDLE;
            x_q       <= 8'd0;
            y_q       <= 6'd0;
            act_q     <= 1'b0;
            // A vblank already in progress at reset release is not an edge.
            vb_prev_q <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
            wr_buf_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            act_q     <= act_d;
            vb_prev_q <= vblank;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_buf_q  <= ~act_d;
            busy_q    <= (state_d != c_IDLE);
        end
    end

`ifdef TEXT_CTRL_CLEAR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_cnt_q <= '0;
            colour_q  <= 8'h00;
        end else begin
            clr_cnt_q <= clr_cnt_d;
            colour_q  <= colour_d;
        end
    end
`endif

    assign wr_en      = wr_en_q;
    assign wr_buf     = wr_buf_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign active_buf = act_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: doc/text_ctrl.md
# text_ctrl

Command sequencer for the GPU's double-buffered text RAM. Accepts 2-bit command / 8-bit data pairs from the CPU interface over a valid/ready handshake. Converts them into single-port write cycles on the back buffer, tracks the text cursor, and defers buffer swaps to the vertical blanking interval so scanout never tears. It sits between the CPU bus interrupt port and the text RAM write port of the GPU; scanout reads the RAM independently using `active_buf`.

## Interface
- `COLS`, 80 — text columns; row stride is 2*COLS bytes (glyph byte, then colour byte per cell).
- `ROWS`, 60 — text rows.
- `AW`, 14 — write address width; must satisfy 2^AW >= 2*COLS*ROWS.

Ports:
- `clk` in 1 — pixel clock, rising-edge.
- `rst` in 1 — asynchronous, active-low reset.
- `cmd_valid` in 1 — command present.
- `cmd_code` in 2 — 00 STORE_BYTE, 01 MOVE_CURSOR, 10 DISPLAY, 11 CLEAR.
- `cmd_data` in 8 — command operand.
- `cmd_ready` out 1 — command is accepted on a rising edge where `cmd_valid && cmd_ready`.
- `vblank` in 1 — high while the v counter is at or above the display height; synchronous to `clk`.
- `wr_en` out 1 — RAM write strobe, one byte per cycle.
- `wr_buf` out 1 — buffer index for the write; always equals ~`active_buf` at the time of the write.
- `wr_addr` out AW — byte address, computed as y*2*COLS + x.
- `wr_data` out 8 — write byte.
- `active_buf` out 1 — buffer currently scanned out.
- `busy` out 1 — high in CLEAR or SWAP_WAIT.

## Operation
- States are IDLE, CLEAR and SWAP_WAIT. `cmd_ready` = (state == IDLE).
- Cursor registers: x is 8 bits (0..2*COLS-1, byte column) and y is 6 bits (0..ROWS-1).
- STORE_BYTE:
  - Writes `cmd_data` at (x,y) of the back buffer.
  - Then x+1. At x = 2*COLS-1, x becomes 0 and y becomes y+1. At (2*COLS-1, ROWS-1), the cursor wraps to (0,0).
  - Remains in IDLE.
- MOVE_CURSOR, absolute:
  - `cmd_data[7]`=1: y = `cmd_data[5:0]`, saturated to ROWS-1.
  - `cmd_data[7]`=0: x = 2*`cmd_data[6:0]`, i.e. a cell column, with the cell column saturated to COLS-1.
  - No write.
- DISPLAY:
  - Goes to SWAP_WAIT.
  - On the first cycle where `vblank` is high and was low the previous cycle, `active_buf` toggles and the state returns to IDLE.
  - If `vblank` is already high at accept, the controller waits for the next rising edge.
- CLEAR:
  - Goes to CLEAR and sweeps addresses 0..2*COLS*ROWS-1 of the back buffer, one per cycle.
  - Even addresses are written 0x00; odd addresses are written `cmd_data` (the colour byte latched at accept).
  - After the final write the state returns to IDLE, and the cursor is set to (0,0) on the same edge.
- Arithmetic: the address is computed from y*2*COLS + x in AW bits, with no overflow for the legal ranges. The sweep counter is AW bits.
- Reset, asynchronous at any time including mid-CLEAR or in SWAP_WAIT:
  - state IDLE, cursor (0,0), `active_buf`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `wr_buf`=1, `busy`=0, `cmd_ready`=1, vblank history=1.
  - A partially completed clear is abandoned.
  - Setting the vblank history to 1 means a vblank already in progress at reset release does not count as a rising edge.

## Timing
- All outputs except `cmd_ready` are registered.
- STORE_BYTE accepted at edge N:
  - `wr_en`/`wr_addr`/`wr_data` are valid for exactly the cycle following edge N.
  - The cursor update is visible after edge N.
  - The next command can be accepted at edge N+1 (throughput 1 per cycle).
- MOVE_CURSOR: the effect is visible after the accept edge. A STORE accepted on the next edge uses the new cursor.
- CLEAR accepted at edge N:
  - `wr_en` is high for cycles N+1 .. N+2*COLS*ROWS (9600 cycles by default), with contiguous addresses.
  - `cmd_ready` returns high after the last write edge.
- DISPLAY:
  - `active_buf` toggles on the edge where rising `vblank` is detected. This is 1 cycle after `vblank` goes high, because the previous value is registered.
  - `cmd_ready` returns high on that same edge.
  - `wr_buf` for later writes reflects the new back buffer.
- Simultaneous events: a `vblank` rising edge while in IDLE or CLEAR has no effect; only SWAP_WAIT consumes it. No command is accepted while `busy`.

## Configuration
- `TEXT_CTRL_CLEAR_EN` defined: CLEAR operates as described.
- `TEXT_CTRL_CLEAR_EN` undefined: code 11 is accepted in one cycle as a no-op. There is no state change, no write, and the cursor is unchanged. The CLEAR state and its sweep counter are not synthesised.

## Test plan
- Reset, then STORE 0x41: `wr_en` pulses 1 cycle with `wr_addr`=0, `wr_data`=0x41 and `wr_buf`=1; the cursor becomes (1,0).
- MOVE_CURSOR 0xBB (y=59), then 0x4F (cell 79), then STORE ×2: writes go to addr 9598 and 9599, and the cursor wraps to (0,0).
- MOVE_CURSOR 0x85 (y=5) and 0x7F (cell clamps to 79): a STORE writes addr 5*160+158=958.
- DISPLAY with `vblank` low; raise `vblank` 100 cycles later:
  - `active_buf` goes 0→1 one cycle after the rise.
  - `busy` is high throughout the wait.
  - A STORE issued afterwards uses `wr_buf`=0.
- DISPLAY issued while `vblank` is high: no toggle until `vblank` falls and rises again.
- CLEAR 0x1F (macro defined):
  - Exactly 9600 writes occur, with 0x00 at even addresses and 0x1F at odd addresses.
  - `cmd_ready` stays low for 9600 cycles.
  - A `rst` pulse at write 500 stops writes immediately and restores all reset values.
